// File: rtl/move_sequencer_pkg.sv
// move_sequencer_pkg
// Shared definitions for the move sequencer slice: sequencer state encoding,
// per-axis word widths, the width of one queued move command and a helper
// that returns the unsigned magnitude of a signed step word.
// No ports (package).
package move_sequencer_pkg;

  localparam int STEP_W     = 32;
  localparam int SPEED_W    = 32;
  localparam int AXIS_CMD_W = STEP_W + SPEED_W;

  // One queued command carries a step word and a speed word for every axis.
  function automatic int cmd_width(input int axes);
    return axes * AXIS_CMD_W;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_RELEASE
  } seq_state_t;

  // Step words are two's-complement when the direction bit is set.
  function automatic logic [STEP_W-1:0] step_magnitude(input logic [STEP_W-1:0] word);
    return word[STEP_W-1] ? (~word + {{(STEP_W-1){1'b0}}, 1'b1}) : word;
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// move_sequencer_if
// Move command handshake bundle between a command source and the sequencer.
//   cmd_valid  : command present
//   cmd_ready  : sequencer can accept (transfer on cmd_valid & cmd_ready)
//   cmd_steps  : AXES x 32-bit step words, axis i at [32i+31:32i]
//   cmd_speed  : AXES x 32-bit half-period words, axis i at [32i+31:32i]
// Modports: master (command source), slave (sequencer).
interface move_sequencer_if #(
  parameter int AXES = 4
) ();
  import move_sequencer_pkg::*;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [AXES*STEP_W-1:0]    cmd_steps;
  logic [AXES*SPEED_W-1:0]   cmd_speed;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_speed,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_speed,
    output cmd_ready
  );

endinterface

// File: rtl/move_sequencer_fifo.sv
// move_fifo
// Synchronous first-word-fall-through FIFO holding queued move commands.
//   clk, reset : clock and synchronous active-high reset
//   push       : write wr_data (ignored while full)
//   pop        : drop the head entry (ignored while empty)
//   flush      : discard every entry
//   wr_data    : command written on push
//   rd_data    : current head entry
//   full/empty : occupancy flags
// DEPTH must be a power of two, at least 2.
module move_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The extra pointer bit tells a full queue from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rd_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer
// Queues multi-axis move commands and sequences them one at a time onto a set
// of stepper drivers: load a command, raise start_driving on the axes that
// actually move, wait until those drivers go idle, then drop start_driving for
// one cycle so the drivers re-arm and report completion.
//   clk, reset       : clock, synchronous active-high reset
//   cmd              : move command handshake (move_sequencer_if.slave)
//   abort            : level; stops motion and flushes the queue
//   step_in, speed   : registered per-axis step and half-period words
//   start_driving    : per-axis start level to the drivers
//   stepper_driving  : per-axis busy from the drivers
//   busy             : any move in progress or queued
//   move_done        : one-cycle pulse per completed move
//   moves_completed  : wrapping count of completed moves
//   fault            : sticky watchdog fault
// Optional feature: define MOVE_SEQ_TIMEOUT_EN to enable the per-move
// watchdog limited by TIMEOUT_CYCLES; otherwise fault is tied low.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int          AXES           = 4,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  move_sequencer_if.slave         cmd,
  input  logic                    abort,
  output logic [AXES*STEP_W-1:0]  step_in,
  output logic [AXES*SPEED_W-1:0] speed,
  output logic [AXES-1:0]         start_driving,
  input  logic [AXES-1:0]         stepper_driving,
  output logic                    busy,
  output logic                    move_done,
  output logic [31:0]             moves_completed,
  output logic                    fault
);

  localparam int CMD_W = cmd_width(AXES);

  seq_state_t               state;
  seq_state_t               state_next;
  logic [CMD_W-1:0]         fifo_rd;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_pop;
  logic                     push;
  logic                     stop;
  logic                     timeout_hit;
  logic                     axes_idle;
  logic [AXES-1:0]          active_mask;
  logic [AXES-1:0]          load_mask;
  logic [AXES*STEP_W-1:0]   head_steps;
  logic [AXES*SPEED_W-1:0]  head_speed;
  logic [AXES*SPEED_W-1:0]  load_speed;

  // A watchdog expiry is treated exactly like an external abort.
  assign stop          = abort || timeout_hit;
  assign cmd.cmd_ready = !fifo_full && !stop;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign head_steps    = fifo_rd[AXES*STEP_W-1:0];
  assign head_speed    = fifo_rd[CMD_W-1:AXES*STEP_W];
  assign axes_idle     = ((stepper_driving & active_mask) == '0);

  move_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (fifo_pop),
    .flush   (stop),
    .wr_data ({cmd.cmd_speed, cmd.cmd_steps}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Per-axis decode of the queue head: an axis participates only if it has a
  // non-zero magnitude, and a zero half-period would never toggle so it is
  // promoted to the fastest legal value.
  always_comb begin
    load_mask  = '0;
    load_speed = '0;
    for (int i = 0; i < AXES; i++) begin
      load_mask[i] = (step_magnitude(head_steps[i*STEP_W +: STEP_W]) != '0);
      load_speed[i*SPEED_W +: SPEED_W] = (head_speed[i*SPEED_W +: SPEED_W] == '0) ?
                                         SPEED_W'(1) : head_speed[i*SPEED_W +: SPEED_W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; abort or watchdog returns to IDLE from anywhere.
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (!fifo_empty) state_next = ST_LOAD;
        ST_LOAD:    state_next = ST_ARM;
        ST_ARM:     state_next = ST_RUN;
        ST_RUN:     if (axes_idle) state_next = ST_RELEASE;
        ST_RELEASE: state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode. start_driving is also gated by reset so a reset mid-move
  // releases the drivers in the very cycle it is asserted.
  always_comb begin
    start_driving = '0;
    fifo_pop      = 1'b0;
    busy          = (state != ST_IDLE) || !fifo_empty;
    if ((state == ST_ARM || state == ST_RUN) && !reset) start_driving = active_mask;
    if (state == ST_LOAD) fifo_pop = 1'b1;
  end

  // Command registers captured while the head is popped in LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_in     <= '0;
      speed       <= '0;
      active_mask <= '0;
    end else if (state == ST_LOAD && !stop) begin
      step_in     <= head_steps;
      speed       <= load_speed;
      active_mask <= load_mask;
    end
  end

  // Completion pulse and counter update together, the cycle after RELEASE.
  always_ff @(posedge clk) begin
    if (reset) begin
      move_done       <= 1'b0;
      moves_completed <= '0;
    end else begin
      move_done <= (state == ST_RELEASE) && !stop;
      if (state == ST_RELEASE && !stop) moves_completed <= moves_completed + 32'd1;
    end
  end

`ifdef MOVE_SEQ_TIMEOUT_EN
  logic [31:0] run_cycles;
  logic        fault_q;

  // run_cycles holds the number of RUN cycles already spent, so the limit is
  // reached during the TIMEOUT_CYCLES-th RUN cycle if the move is still busy.
  assign timeout_hit = (state == ST_RUN) && !axes_idle &&
                       (run_cycles == TIMEOUT_CYCLES - 32'd1);
  assign fault       = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles <= '0;
      fault_q    <= 1'b0;
    end else begin
      if (state == ST_ARM)      run_cycles <= '0;
      else if (state == ST_RUN) run_cycles <= run_cycles + 32'd1;
      if (timeout_hit) fault_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer
// Bench for move_sequencer: a queue-based move model predicts every output on
// every cycle, a small stepper-driver model answers start_driving, and
// directed moves plus randomized commands exercise queueing, abort and reset.
// Honours MOVE_SEQ_TIMEOUT_EN (runs the stuck-driver watchdog case).
module tb_move_sequencer;
  import move_sequencer_pkg::*;

  localparam int AXES  = 4;
  localparam int DEPTH = 4;
`ifdef MOVE_SEQ_TIMEOUT_EN
  localparam logic [31:0] TMO = 32'd1000;
`else
  localparam logic [31:0] TMO = 32'd500_000_000;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         abort = 1'b0;
  logic [3:0]   stepper_driving = 4'b0;
  logic [127:0] step_in;
  logic [127:0] speed;
  logic [3:0]   start_driving;
  logic         busy;
  logic         move_done;
  logic [31:0]  moves_completed;
  logic         fault;

  move_sequencer_if #(.AXES(AXES)) cmd_bus ();

  move_sequencer #(
    .AXES           (AXES),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd             (cmd_bus),
    .abort           (abort),
    .step_in         (step_in),
    .speed           (speed),
    .start_driving   (start_driving),
    .stepper_driving (stepper_driving),
    .busy            (busy),
    .move_done       (move_done),
    .moves_completed (moves_completed),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural move model ----------------
  typedef struct { logic [127:0] steps; logic [127:0] spd; } move_t;

  move_t       mq[$];
  move_t       cur;
  bit          model_on  = 0;
  bit          in_move   = 0;
  bit          releasing = 0;
  int          age       = 0;
  bit          done_exp  = 0;
  logic [31:0] done_cnt  = 0;
  bit          fault_exp = 0;
  bit          push_seen = 0;

  function automatic logic [3:0] mask_of(input logic [127:0] s);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (s[32*i +: 32] != 32'd0);
    return m;
  endfunction

  function automatic logic [127:0] spd_fix(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = (s[32*i +: 32] == 32'd0) ? 32'd1 : s[32*i +: 32];
    return r;
  endfunction

  function automatic int absval(input logic [31:0] w);
    return w[31] ? int'(~w + 32'd1) : int'(w);
  endfunction

  function automatic bit run_busy();
    return in_move && !releasing && age >= 2 && ((stepper_driving & mask_of(cur.steps)) != 4'b0);
  endfunction

  function automatic bit tmo_now();
`ifdef MOVE_SEQ_TIMEOUT_EN
    return run_busy() && (age - 1 == int'(TMO));
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit ready_now();
    return (mq.size() < DEPTH) && !abort && !tmo_now();
  endfunction

  // Model advance at each clock edge, from the inputs the DUT samples there.
  always @(posedge clk) begin
    bit    push;
    bit    complete;
    bit    tmo;
    move_t s;
    push_seen = 0;
    if (reset) begin
      mq.delete();
      in_move = 0; releasing = 0; age = 0; done_exp = 0;
      done_cnt = 0; fault_exp = 0; model_on = 1;
      cur.steps = '0; cur.spd = '0;
    end else if (model_on) begin
      complete = in_move && !releasing && age >= 2 && !run_busy();
      tmo      = tmo_now();
      push     = cmd_bus.cmd_valid && ready_now();
      done_exp = in_move && releasing && !abort;
      if (done_exp) done_cnt = done_cnt + 32'd1;
      if (abort || tmo) begin
        mq.delete();
        in_move = 0; releasing = 0;
        if (tmo) fault_exp = 1;
      end else begin
        if (!in_move) begin
          if (mq.size() > 0) begin in_move = 1; age = 0; cur = mq[0]; end
        end else if (releasing) begin
          in_move = 0; releasing = 0;
        end else begin
          if (age == 0) void'(mq.pop_front());
          if (complete) releasing = 1;
          age++;
        end
        if (push) begin
          s.steps = cmd_bus.cmd_steps;
          s.spd   = cmd_bus.cmd_speed;
          mq.push_back(s);
        end
      end
      push_seen = push;
    end
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clk) begin
    logic [3:0] exp_start;
    if (model_on) begin
      exp_start = (in_move && !releasing && age >= 1 && !reset) ? mask_of(cur.steps) : 4'b0;
      check_output("cmd_ready", cmd_bus.cmd_ready, ready_now());
      check_output("busy", busy, in_move || (mq.size() > 0));
      check_output("start_driving", start_driving, exp_start);
      check_output("move_done", move_done, done_exp);
      check_output("moves_completed", moves_completed, done_cnt);
      check_output("fault", fault, fault_exp);
      if (in_move && age >= 1) begin
        check_output("step_in", step_in, cur.steps);
        check_output("speed", speed, spd_fix(cur.spd));
      end
    end
  end

  // ---------------- stepper driver model ----------------
  // Goes busy one cycle after seeing start, stays busy |steps|*speed cycles,
  // and will not restart until start_driving has dropped.
  logic [3:0]   cap_start;
  logic [127:0] cap_steps;
  logic [127:0] cap_spd;
  logic         cap_reset;
  int           left [4];
  bit           armed [4];
  bit           stuck = 0;

  always @(negedge clk) begin
    cap_start = start_driving;
    cap_steps = step_in;
    cap_spd   = speed;
    cap_reset = reset;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (cap_reset === 1'b1) begin
        left[i] = 0; armed[i] = 0;
      end else if (cap_start[i] === 1'b1 && !armed[i]) begin
        armed[i] = 1;
        left[i]  = absval(cap_steps[32*i +: 32]) * int'(cap_spd[32*i +: 32]);
      end else if (left[i] > 0) begin
        left[i]--;
      end
      if (cap_start[i] !== 1'b1) armed[i] = 0;
      stepper_driving[i] = stuck || (left[i] > 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_stimulus(input logic [127:0] steps, input logic [127:0] spd);
    bit ok = 0;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_steps = steps;
    cmd_bus.cmd_speed = spd;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (push_seen) begin ok = 1; break; end
    end
    cmd_bus.cmd_valid = 1'b0;
    if (!ok) check_output("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (start_driving == 4'b0 && n < 20) begin @(negedge clk); n++; end
    if (start_driving == 4'b0) check_output("start_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (move_done !== 1'b1 && n < budget);
    if (move_done !== 1'b1) check_output("done_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((in_move || mq.size() > 0) && n < 5000) begin step(); n++; end
    if (in_move || mq.size() > 0) check_output("idle_timeout", 0, 1);
    step(); step();
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] e, input logic [31:0] z,
                                         input logic [31:0] y, input logic [31:0] x);
    return {e, z, y, x};
  endfunction

  function automatic logic [31:0] rand_step();
    logic [31:0] w;
    if ($urandom_range(1, 0) == 0) return 32'd0;
    w = 32'($urandom_range(8, 1));
    if ($urandom_range(1, 0) == 1) w = ~w + 32'd1;
    return w;
  endfunction

  initial begin
    #700_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_steps = '0;
    cmd_bus.cmd_speed = '0;
    for (int i = 0; i < 4; i++) begin left[i] = 0; armed[i] = 0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("rst_cmd_ready", cmd_bus.cmd_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_start", start_driving, 0);
    check_output("rst_done", move_done, 0);
    check_output("rst_count", moves_completed, 0);
    check_output("rst_fault", fault, 0);
    check_output("rst_step_in", step_in, 0);
    check_output("rst_speed", speed, 0);
    step();

    // Single X move.
    $display("[TB] single X move");
    apply_stimulus(pack4(0, 0, 0, 32'd100), pack4(0, 0, 0, 32'd10));
    wait_start(n);
    check_output("x_start_mask", start_driving, 4'b0001);
    check_output("x_step_word", step_in[31:0], 32'd100);
    wait_done(1500, n);
    check_output("x_count", moves_completed, 1);
    wait_idle();

    // Two axes, E runs longer than X.
    $display("[TB] X/E move");
    apply_stimulus(pack4(32'd200, 0, 0, 32'hFFFF_FFCE), pack4(32'd3, 0, 0, 32'd5));
    wait_start(n);
    check_output("xe_start_mask", start_driving, 4'b1001);
    wait_done(1000, n);
    check_output("xe_done_latency", n, 603);
    check_output("xe_count", moves_completed, 2);
    wait_idle();

    // All-zero command.
    $display("[TB] zero move");
    apply_stimulus('0, '0);
    wait_done(20, n);
    check_output("zero_done_latency", n, 6);
    wait_idle();

    // Fill the queue behind a long move.
    $display("[TB] queue full");
    apply_stimulus(pack4(0, 0, 0, 32'd40), pack4(0, 0, 0, 32'd5));
    wait_start(n);
    step();
    for (int k = 0; k < 4; k++)
      apply_stimulus(pack4(0, 0, 32'(k + 1), 0), pack4(0, 0, 32'd1, 0));
    @(negedge clk);
    check_output("full_cmd_ready", cmd_bus.cmd_ready, 0);
    check_output("full_busy", busy, 1);
    step();
    apply_stimulus(pack4(32'd2, 0, 0, 0), 0);
    wait_idle();
    check_output("full_count", moves_completed, 9);

    // Five back-to-back commands from idle.
    $display("[TB] back-to-back");
    for (int k = 0; k < 5; k++)
      apply_stimulus(pack4(0, 32'(k), 0, 0), pack4(0, 32'd2, 0, 0));
    wait_idle();
    check_output("b2b_count", moves_completed, 14);

    // Abort mid-RUN with two queued.
    $display("[TB] abort");
    apply_stimulus(pack4(0, 0, 0, 32'd30), pack4(0, 0, 0, 32'd10));
    apply_stimulus(pack4(0, 0, 32'd4, 0), pack4(0, 0, 32'd1, 0));
    apply_stimulus(pack4(32'd4, 0, 0, 0), pack4(32'd1, 0, 0, 0));
    wait_start(n);
    repeat (20) step();
    abort = 1'b1;
    @(negedge clk);
    check_output("abort_cmd_ready", cmd_bus.cmd_ready, 0);
    step();
    abort = 1'b0;
    @(negedge clk);
    check_output("abort_start", start_driving, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_count", moves_completed, 14);
    repeat (30) step();
    check_output("abort_count_later", moves_completed, 14);

    // Reset in the middle of a move.
    $display("[TB] reset mid-move");
    apply_stimulus(pack4(0, 0, 0, 32'd20), pack4(0, 0, 0, 32'd2));
    wait_start(n);
    step();
    reset = 1'b1;
    @(negedge clk);
    check_output("rst_mid_start", start_driving, 0);
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    check_output("rst_mid_count", moves_completed, 0);
    check_output("rst_mid_busy", busy, 0);
    step();

    // Randomized commands, gaps and occasional aborts.
    $display("[TB] random");
    for (int k = 0; k < 40; k++) begin
      apply_stimulus(pack4(rand_step(), rand_step(), rand_step(), rand_step()),
                     pack4(32'($urandom_range(3, 0)), 32'($urandom_range(3, 0)),
                           32'($urandom_range(3, 0)), 32'($urandom_range(3, 0))));
      repeat ($urandom_range(6, 0)) step();
      if ($urandom_range(14, 0) == 0) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
      end
    end
    wait_idle();

`ifdef MOVE_SEQ_TIMEOUT_EN
    // Driver stuck busy: watchdog fires after TMO RUN cycles.
    $display("[TB] watchdog");
    stuck = 1;
    apply_stimulus(pack4(0, 0, 0, 32'd5), pack4(0, 0, 0, 32'd1));
    wait_start(n);
    n = 0;
    while (fault !== 1'b1 && n < 1200) begin @(negedge clk); n++; end
    check_output("tmo_latency", n, 1001);
    check_output("tmo_start", start_driving, 0);
    check_output("tmo_busy", busy, 0);
    repeat (10) step();
    check_output("tmo_sticky", fault, 1);
    stuck = 0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    check_output("tmo_cleared", fault, 0);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
